// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank
// APB completer with a small register bank, programmable wait states and
// PSLVERR signalling.
//   word 0         : ID (read-only, ID_VALUE)
//   word 1         : ERR_CNT (read-only, 8-bit saturating count of errors)
//   word 2..N-1    : read/write registers
// A transfer is taken in IDLE on a setup cycle (PSEL=1, PENABLE=0). ACCESS
// burns WAIT_slv_i extra cycles and then commits. RESP presents a one-cycle
// registered response.
module apb_slave_regbank #(
    parameter int                      DATA_WIDTH = 32,
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      NUM_REGS   = 8,
    parameter int                      WAIT_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0]   ID_VALUE   = 32'hA5B0_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL_slv_i,
    input  logic                  PENABLE_slv_i,
    input  logic                  PWRITE_slv_i,
    input  logic [ADDR_WIDTH-1:0] PADDR_slv_i,
    input  logic [DATA_WIDTH-1:0] PWDATA_slv_i,
    output logic [DATA_WIDTH-1:0] PRDATA_slv_o,
    output logic                  PREADY_slv_o,
    output logic                  PSLVERR_slv_o,
    input  logic [WAIT_WIDTH-1:0] WAIT_slv_i,
    output logic                  BUSY_slv_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [WAIT_WIDTH-1:0]   cnt;
    logic [WAIT_WIDTH-1:0]   cnt_nxt;

    // Transfer captured during the setup cycle.
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    // Storage for the read/write words only; words 0 and 1 are not storage.
    logic [DATA_WIDTH-1:0]   regs [2:NUM_REGS-1];
    logic [7:0]              err_cnt;

    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    pready_q;
    logic                    pslverr_q;

    // Decode of the latched transfer.
    logic [IDX_W-1:0]        idx;
    logic [SEL_W-1:0]        sel;
    logic                    in_range;
    logic                    is_err;
    logic                    take_setup;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign idx        = addr_q[ADDR_WIDTH-1:2];
    assign sel        = idx[SEL_W-1:0];
    assign in_range   = (idx < IDX_W'(NUM_REGS));
    assign is_err     = (addr_q[1:0] != 2'b00) || !in_range || (write_q && (idx < IDX_W'(2)));
    assign take_setup = (state == IDLE) && PSEL_slv_i && !PENABLE_slv_i;
    assign commit     = (state == ACCESS) && PSEL_slv_i && (cnt == '0);

    // Read mux over the register map; out-of-range words read as zero.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rd_data = '0;
        if (in_range) begin
            if (idx == IDX_W'(0)) begin
                rd_data = ID_VALUE;
            end else if (idx == IDX_W'(1)) begin
                rd_data = {{(DATA_WIDTH-8){1'b0}}, err_cnt};
            end else begin
                rd_data = regs[sel];
            end
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (take_setup) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = WAIT_slv_i;
                end
            end
            ACCESS: begin
                if (!PSEL_slv_i) begin
                    // Master gave up: drop the transfer silently.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!PRESETn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture address, direction and write data on the setup cycle.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (take_setup) begin
            addr_q  <= PADDR_slv_i;
            write_q <= PWRITE_slv_i;
            wdata_q <= PWDATA_slv_i;
        end
    end

    // Registered response: raised at commit, PREADY/PSLVERR dropped after RESP.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else if (commit) begin
            pready_q  <= 1'b1;
            pslverr_q <= is_err;
            prdata_q  <= (is_err || write_q) ? '0 : rd_data;
        end else if (state == RESP) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end
    end

    // Read/write register storage, updated only on an error-free write commit.
    always_ff @(posedge PCLK) begin
        // NOTE: this register file is small and architecturally defined to
        // read zero after reset, so it is reset explicitly (unlike a RAM).
        if (!PRESETn) begin
            for (int i = 2; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && write_q && !is_err) begin
            regs[sel] <= wdata_q;
        end
    end

    // Saturating error counter, bumped at the same edge as the response.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            err_cnt <= '0;
        end else if (commit && is_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign PRDATA_slv_o  = prdata_q;
    assign PREADY_slv_o  = pready_q;
    assign PSLVERR_slv_o = pslverr_q;
    assign BUSY_slv_o    = (state != IDLE);

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank
// Directed bench: a master task drives APB transfers and pushes the expected
// response into a scoreboard queue; a negedge monitor pops and compares it
// whenever PREADY is seen.
module tb_apb_slave_regbank;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int WW = 4;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [WW-1:0] wait_i;
    logic          busy;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          chk_data;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    logic pready_prev = 1'b0;

    always #5 pclk = ~pclk;

    apb_slave_regbank dut (
        .PCLK          (pclk),
        .PRESETn       (presetn),
        .PSEL_slv_i    (psel),
        .PENABLE_slv_i (penable),
        .PWRITE_slv_i  (pwrite),
        .PADDR_slv_i   (paddr),
        .PWDATA_slv_i  (pwdata),
        .PRDATA_slv_o  (prdata),
        .PREADY_slv_o  (pready),
        .PSLVERR_slv_o (pslverr),
        .WAIT_slv_i    (wait_i),
        .BUSY_slv_o    (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard monitor and bus invariants, sampled away from the rising edge.
    always @(negedge pclk) begin
        check("pslverr_only_with_pready", 32'(pslverr && !pready), 32'd0);
        if (pready) begin
            exp_t e;
            check("pready_single_cycle", 32'(pready_prev), 32'd0);
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("resp_pslverr", 32'(pslverr), 32'(e.err));
                if (e.chk_data) check("resp_prdata", prdata, e.data);
            end
        end
        pready_prev = pready;
    end

    // One complete transfer: setup, access until PREADY, then release the bus.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                        input logic [WW-1:0] ws, input logic [DW-1:0] exp_data, input logic exp_err);
        exp_t e;
        int   cycles;
        e.data     = exp_data;
        e.err      = exp_err;
        e.chk_data = !wr || exp_err;
        sb_q.push_back(e);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        wait_i  = ws;
        @(negedge pclk);
        penable = 1'b1;
        cycles  = 1;
        while (!pready && cycles < 64) begin
            @(negedge pclk);
            cycles++;
        end
        check("access_cycles", 32'(cycles), 32'(ws) + 32'd2);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Start a transfer and leave it in ACCESS after `n` access cycles.
    task automatic start_and_hold(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                  input logic [WW-1:0] ws, input int n);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = wdata;
        wait_i  = ws;
        @(negedge pclk);
        penable = 1'b1;
        repeat (n) begin
            check("hold_no_pready", 32'(pready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            @(negedge pclk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        wait_i  = '0;
        repeat (3) @(negedge pclk);
        check("reset_prdata", prdata, 32'd0);
        check("reset_pready", 32'(pready), 32'd0);
        check("reset_pslverr", 32'(pslverr), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        presetn = 1'b1;

        // Basic write/read, minimum latency.
        xfer(32'h8, 1'b1, 32'hDEAD_BEEF, 4'd0, 32'h0, 1'b0);
        xfer(32'h8, 1'b0, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);

        // ID read with wait states.
        xfer(32'h0, 1'b0, 32'h0, 4'd5, 32'hA5B0_0001, 1'b0);

        // Highest valid word.
        xfer(32'h1C, 1'b1, 32'hCAFE_F00D, 4'd1, 32'h0, 1'b0);
        xfer(32'h1C, 1'b0, 32'h0, 4'd3, 32'hCAFE_F00D, 1'b0);

        // Error responses: RO writes, out of range, misaligned.
        xfer(32'h0, 1'b1, 32'h1111_1111, 4'd0, 32'h0, 1'b1);
        xfer(32'h4, 1'b1, 32'h2222_2222, 4'd2, 32'h0, 1'b1);
        xfer(32'h20, 1'b0, 32'h0, 4'd0, 32'h0, 1'b1);
        xfer(32'h9, 1'b0, 32'h0, 4'd1, 32'h0, 1'b1);
        xfer(32'h4, 1'b0, 32'h0, 4'd0, 32'd4, 1'b0);
        xfer(32'h0, 1'b0, 32'h0, 4'd0, 32'hA5B0_0001, 1'b0);
        xfer(32'h8, 1'b0, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);

        // Misaligned write to a valid word must not land.
        xfer(32'hA, 1'b1, 32'h5555_5555, 4'd0, 32'h0, 1'b1);
        xfer(32'h8, 1'b0, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
        xfer(32'h4, 1'b0, 32'h0, 4'd0, 32'd5, 1'b0);

        // Master timeout: drop PSEL mid-ACCESS.
        xfer(32'hC, 1'b1, 32'h1234_5678, 4'd0, 32'h0, 1'b0);
        start_and_hold(32'hC, 32'hFFFF_FFFF, 4'd10, 3);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pready", 32'(pready), 32'd0);
        xfer(32'hC, 1'b0, 32'h0, 4'd0, 32'h1234_5678, 1'b0);

        // Saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            xfer(32'h0, 1'b1, 32'(i), 4'd0, 32'h0, 1'b1);
        end
        xfer(32'h4, 1'b0, 32'h0, 4'd0, 32'd255, 1'b0);

        // Reset in the middle of ACCESS.
        xfer(32'hC, 1'b0, 32'h0, 4'd0, 32'h1234_5678, 1'b0);
        start_and_hold(32'h10, 32'h7777_7777, 4'd10, 2);
        presetn = 1'b0;
        @(negedge pclk);
        check("midreset_prdata", prdata, 32'd0);
        check("midreset_pready", 32'(pready), 32'd0);
        check("midreset_pslverr", 32'(pslverr), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        presetn = 1'b1;
        xfer(32'h8, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);
        xfer(32'hC, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);
        xfer(32'h10, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);
        xfer(32'h1C, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);
        xfer(32'h4, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);

        @(negedge pclk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB completer (slave) for the APB master block: a small register bank with programmable wait states and error signalling.
- Connects directly to the master's PSEL/PENABLE/PWRITE/PADDR/PWDATA outputs and drives PRDATA/PREADY/PSLVERR back to it.
- Serves as the bus target in subsystem benches and as the slave-side reference for PREADY, PSLVERR and timeout interaction.

Parameters:
- DATA_WIDTH, 32, data bus width; same value as the team parameters header.
- ADDR_WIDTH, 32, address bus width; same value as the team parameters header.
- NUM_REGS, 8, number of word registers (>=3).
- WAIT_WIDTH, 4, width of the wait-state count input.
- ID_VALUE, 32'hA5B0_0001, constant read from register 0.

Ports:
- PCLK  in  1  clock. Reset is synchronous and active-low; one clock domain.
- PRESETn  in  1  synchronous active-low reset.
- PSEL_slv_i  in  1  slave select.
- PENABLE_slv_i  in  1  access-phase indicator.
- PWRITE_slv_i  in  1  1 = write, 0 = read.
- PADDR_slv_i  in  ADDR_WIDTH  byte address.
- PWDATA_slv_i  in  DATA_WIDTH  write data.
- PRDATA_slv_o  out  DATA_WIDTH  read data (registered).
- PREADY_slv_o  out  1  transfer complete (registered).
- PSLVERR_slv_o  out  1  transfer error (registered).
- WAIT_slv_i  in  WAIT_WIDTH  extra wait cycles; sampled in the setup cycle.
- BUSY_slv_o  out  1  high while state != IDLE.

Behaviour:
- Reset (PRESETn=0 at a PCLK edge):
  - All outputs go to 0, state = IDLE, wait counter = 0.
  - RW registers = 0; ERR_CNT = 0.
  - Reset mid-transfer aborts with no write and no response.
- Register map (word index = PADDR[..:2]):
  - 0: ID, RO, returns ID_VALUE.
  - 1: ERR_CNT, RO, 8-bit saturating count of PSLVERR responses, zero-extended.
  - 2..NUM_REGS-1: RW.
- Error condition, evaluated on the latched address:
  - PADDR[1:0] != 0, or word index >= NUM_REGS, or a write to index 0 or 1.
  - On error: no register update, PRDATA = 0, PSLVERR = 1, ERR_CNT += 1 (saturates at 255).
- FSM states:
  - IDLE: on an edge with PSEL=1 and PENABLE=0, latch PADDR, PWRITE, PWDATA; load cnt = WAIT_slv_i; go to ACCESS.
  - IDLE with PENABLE=1 but no preceding setup: ignored, stay IDLE.
  - ACCESS: if PSEL=0, go to IDLE (abort, no write, no response). Else if cnt != 0, cnt -= 1. Else (cnt == 0) perform the write or read, register PRDATA/PSLVERR, set PREADY=1, go to RESP.
  - RESP: PREADY, PRDATA and PSLVERR held for exactly one cycle. On the next edge, clear PREADY and PSLVERR, go to IDLE. PRDATA keeps its last value.
  - Back-to-back transfers: a new setup can be accepted on the edge after leaving RESP.
- Latency:
  - Setup sampled at edge k.
  - PREADY is high during the cycle following edge k+1+WAIT_slv_i.
  - The master observes WAIT_slv_i+2 access cycles in total; minimum is 1 wait state.
- Write commit: occurs at the same edge that raises PREADY, using the latched PWDATA.
- ERR_CNT update: happens at that same edge.
- Reads of ERR_CNT: return the pre-update value.
- PREADY is never asserted outside RESP; PSLVERR is high only while PREADY is high.
- Master timeout: the master may drop PSEL while in ACCESS; the slave returns to IDLE on that edge with no side effects.

Test Plan:
- Write 0xDEADBEEF to 0x8 with WAIT=0, then read 0x8 -> PREADY high exactly one cycle per transfer, 2 access cycles each, PRDATA=0xDEADBEEF, PSLVERR=0.
- Read 0x0 with WAIT=5 -> PREADY rises after 6 access cycles, PRDATA=0xA5B00001, PSLVERR=0.
- Write to 0x0, then to 0x4, then read 0x20 and 0x9 -> PSLVERR=1 with PREADY each time, no register change, PRDATA=0; subsequent read of 0x4 returns 4.
- Drop PSEL in ACCESS with WAIT=10 (timeout abort), then read the target register -> no PREADY, register unchanged, BUSY low on the next cycle.
- Assert PRESETn=0 mid-ACCESS, and force 300 errors -> all outputs 0 after the reset edge, registers 0; ERR_CNT reads 255 (saturated).
